// File: rtl/bsg_clk_gen_pearl_pkg.sv
// ============================================================================
// bsg_clk_gen_pearl_pkg : shared types and constants for the clock-gen pearl
// Revision: 1.0
// ============================================================================
`default_nettype none

package bsg_clk_gen_pearl_pkg;

    localparam int bsg_clk_gen_pearl_ds_max_ch_gp        = 16;
    localparam int bsg_clk_gen_pearl_ds_cfg_val_width_gp = 16;

    typedef enum logic [1:0] {
        DISABLED    = 2'd0,
        RUN         = 2'd1,
        RUN_PENDING = 2'd2
    } bsg_clk_gen_pearl_ds_state_e;

    // Widest-case config word; users slice ch/ds_val down to their widths.
    typedef struct packed {
        logic [3:0]                                      ch;
        logic [bsg_clk_gen_pearl_ds_cfg_val_width_gp-1:0] ds_val;
        logic                                            en;
    } bsg_clk_gen_pearl_ds_cfg_s;

    function automatic int bsg_clk_gen_pearl_safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_clk_gen_pearl_ds_channel.sv
// ============================================================================
// bsg_clk_gen_pearl_ds_channel : one programmable divide-by-2(N+1) channel
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_clk_gen_pearl_ds_channel
    import bsg_clk_gen_pearl_pkg::*;
#(
    parameter int ds_width_p    = 8,
    parameter int init_ds_val_p = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  we_i,
    input  logic [ds_width_p-1:0] ds_val_i,
    input  logic                  en_i,
    output logic                  out_o,
    output logic                  pending_v_o
);

    bsg_clk_gen_pearl_ds_state_e state_q, state_d;
    logic [ds_width_p-1:0] ctr_q, ctr_d;
    logic [ds_width_p-1:0] active_val_q, active_val_d;
    logic [ds_width_p-1:0] pending_val_q, pending_val_d;
    logic                  pending_en_q, pending_en_d;
    logic                  pending_v_q, pending_v_d;
    logic                  out_q, out_d;
    logic                  wrap;

    assign wrap        = (ctr_q == active_val_q);
    assign out_o       = out_q;
    assign pending_v_o = pending_v_q;

    always_comb begin
        state_d       = state_q;
        ctr_d         = ctr_q;
        active_val_d  = active_val_q;
        pending_val_d = pending_val_q;
        pending_en_d  = pending_en_q;
        pending_v_d   = pending_v_q;
        out_d         = out_q;

        if (state_q != DISABLED) begin
            if (wrap) begin
                ctr_d = '0;
                out_d = ~out_q;
            end else begin
                ctr_d = ctr_q + ds_width_p'(1);
            end
        end

        case (state_q)
            DISABLED: begin
                ctr_d = '0;
                out_d = 1'b0;
                if (we_i) begin
                    active_val_d = ds_val_i;
                    if (en_i) state_d = RUN;
                end
            end
            RUN: begin
                if (we_i) begin
                    pending_val_d = ds_val_i;
                    pending_en_d  = en_i;
                    pending_v_d   = 1'b1;
                    state_d       = RUN_PENDING;
                end
            end
            RUN_PENDING: begin
                // Swap only at the falling edge so neither phase is ever cut short.
                if (wrap && out_q) begin
                    active_val_d = pending_val_q;
                    pending_v_d  = 1'b0;
                    ctr_d        = '0;
                    out_d        = 1'b0;
                    state_d      = pending_en_q ? RUN : DISABLED;
                end
            end
            default: begin
                state_d = DISABLED;
                ctr_d   = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= DISABLED;
            ctr_q         <= '0;
            active_val_q  <= ds_width_p'(init_ds_val_p);
            pending_val_q <= '0;
            pending_en_q  <= 1'b0;
            pending_v_q   <= 1'b0;
            out_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            active_val_q  <= active_val_d;
            pending_val_q <= pending_val_d;
            pending_en_q  <= pending_en_d;
            pending_v_q   <= pending_v_d;
            out_q         <= out_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsg_clk_gen_pearl_ds_bank.sv
// ============================================================================
// bsg_clk_gen_pearl_ds_bank : bank of runtime-programmable clock monitor dividers
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_clk_gen_pearl_ds_bank
    import bsg_clk_gen_pearl_pkg::*;
#(
    parameter int num_ch_p      = 4,
    parameter int ds_width_p    = 8,
    parameter int init_ds_val_p = 0,
    localparam int ch_width_lp  = bsg_clk_gen_pearl_safe_clog2(num_ch_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   cfg_v_i,
    input  logic [ch_width_lp-1:0] cfg_ch_i,
    input  logic [ds_width_p-1:0]  cfg_ds_val_i,
    input  logic                   cfg_en_i,
    output logic                   cfg_ready_o,
    input  logic                   output_disable_i,
    output logic [num_ch_p-1:0]    clk_monitor_o,
    output logic                   cfg_err_o
);

    logic [num_ch_p-1:0] pending_v;
    logic [num_ch_p-1:0] out_r;
    logic [num_ch_p-1:0] ch_we;
    logic                ch_invalid;
    logic                err_q;
    logic                output_disable_q;

    assign ch_invalid = (32'(cfg_ch_i) >= 32'(num_ch_p));

    // Nonexistent channels report ready so the write drains and flags an error.
    always_comb begin
        cfg_ready_o = 1'b1;
        ch_we       = '0;
        for (int i = 0; i < num_ch_p; i++) begin
            if (32'(cfg_ch_i) == 32'(i)) begin
                cfg_ready_o = ~pending_v[i];
                ch_we[i]    = cfg_v_i & ~pending_v[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            err_q            <= 1'b0;
            output_disable_q <= 1'b0;
        end else begin
            err_q            <= err_q | (cfg_v_i & ch_invalid);
            output_disable_q <= output_disable_i;
        end
    end

    assign cfg_err_o     = err_q;
    assign clk_monitor_o = out_r & {num_ch_p{~output_disable_q}};

    generate
        for (genvar g = 0; g < num_ch_p; g++) begin : g_ch
            bsg_clk_gen_pearl_ds_channel #(
                .ds_width_p    (ds_width_p),
                .init_ds_val_p (init_ds_val_p)
            ) u_channel (
                .clk_i       (clk_i),
                .reset_n_i   (reset_n_i),
                .we_i        (ch_we[g]),
                .ds_val_i    (cfg_ds_val_i),
                .en_i        (cfg_en_i),
                .out_o       (out_r[g]),
                .pending_v_o (pending_v[g])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bsg_clk_gen_pearl_ds_bank.sv
// ============================================================================
// tb_bsg_clk_gen_pearl_ds_bank : directed stimulus with a cycle-stamped scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bsg_clk_gen_pearl_ds_bank;
    import bsg_clk_gen_pearl_pkg::*;

    // Five channels so a 3-bit channel field can address nonexistent channels.
    localparam int NUM_CH  = 5;
    localparam int DS_W    = 8;
    localparam int INIT_DS = 0;
    localparam int CH_W    = bsg_clk_gen_pearl_safe_clog2(NUM_CH);

    localparam int K_BIT = 0;
    localparam int K_RDY = 1;
    localparam int K_ERR = 2;
    localparam int K_VEC = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cfg_v = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [DS_W-1:0]   cfg_ds_val = '0;
    logic              cfg_en = 1'b0;
    logic              cfg_ready;
    logic              output_disable = 1'b0;
    logic [NUM_CH-1:0] clk_monitor;
    logic              cfg_err;

    bsg_clk_gen_pearl_ds_bank #(
        .num_ch_p      (NUM_CH),
        .ds_width_p    (DS_W),
        .init_ds_val_p (INIT_DS)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .cfg_v_i          (cfg_v),
        .cfg_ch_i         (cfg_ch),
        .cfg_ds_val_i     (cfg_ds_val),
        .cfg_en_i         (cfg_en),
        .cfg_ready_o      (cfg_ready),
        .output_disable_i (output_disable),
        .clk_monitor_o    (clk_monitor),
        .cfg_err_o        (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    kind;
        int    idx;
        int    exp;
        string name;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic push(input int c, input int kind, input int idx, input int exp, input string name);
        chk_t e;
        e.cyc = c; e.kind = kind; e.idx = idx; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                int act;
                case (sb[i].kind)
                    K_BIT:   act = {31'b0, clk_monitor[sb[i].idx]};
                    K_RDY:   act = {31'b0, cfg_ready};
                    K_ERR:   act = {31'b0, cfg_err};
                    default: act = 32'(clk_monitor);
                endcase
                n_checks++;
                if (act != sb[i].exp) begin
                    n_errors++;
                    $display("FAIL %s cyc=%0d idx=%0d actual=%0d required=%0d",
                             sb[i].name, cyc, sb[i].idx, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bsg_clk_gen_pearl_ds_cfg_s mk(input int ch, input int val, input bit en);
        bsg_clk_gen_pearl_ds_cfg_s c;
        c.ch     = 4'(ch);
        c.ds_val = 16'(val);
        c.en     = en;
        return c;
    endfunction

    task automatic drive(input bsg_clk_gen_pearl_ds_cfg_s c);
        cfg_v      = 1'b1;
        cfg_ch     = c.ch[CH_W-1:0];
        cfg_ds_val = c.ds_val[DS_W-1:0];
        cfg_en     = c.en;
    endtask

    // Ideal divider waveform: RUN entered with ctr=0/out=0 in cycle s.
    function automatic int div_wave(input int c, input int s, input int v);
        int d;
        d = c - s;
        if (d < 0) return 0;
        return (d / (v + 1)) % 2;
    endfunction

    task automatic do_reset();
        cfg_v          = 1'b0;
        output_disable = 1'b0;
        reset_n        = 1'b0;
        tick();
        tick();
        push(cyc, K_VEC, 0, 0, "reset_vec");
        push(cyc, K_ERR, 0, 0, "reset_err");
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int d;
        logic [15:0] exp_t2;
        logic [23:0] exp_t3;
        exp_t2 = 16'hCCF0;
        exp_t3 = 24'h038FC0;

        // Divide-by-2 on ch0, other channels idle.
        do_reset();
        n_checks++;
        if (clk_monitor !== '0) begin
            n_errors++;
            $display("FAIL direct_reset_vec cyc=%0d actual=%0d required=0", cyc, clk_monitor);
        end
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_errors++;
            $display("FAIL direct_reset_err cyc=%0d actual=%0d required=0", cyc, cfg_err);
        end
        t = cyc;
        drive(mk(0, 0, 1'b1));
        push(t, K_RDY, 0, 1, "t1_ready");
        for (int c = 1; c <= 6; c++) push(t + c, K_VEC, 0, (c % 2 == 0) ? 1 : 0, "t1_vec");
        tick();
        cfg_v = 1'b0;
        repeat (6) tick();

        // ch1 val=3, rewritten to val=1 while high with ctr=1.
        do_reset();
        t = cyc;
        drive(mk(1, 3, 1'b1));
        for (int c = 1; c <= 16; c++) push(t + c, K_BIT, 1, int'(exp_t2[c-1]), "t2_out1");
        push(t + 6, K_RDY, 0, 1, "t2_ready_pre");
        push(t + 7, K_RDY, 0, 0, "t2_ready_pend");
        push(t + 8, K_RDY, 0, 0, "t2_ready_apply");
        push(t + 9, K_RDY, 0, 1, "t2_ready_post");
        tick();
        cfg_v = 1'b0;
        repeat (5) tick();
        drive(mk(1, 1, 1'b1));
        tick();
        cfg_v = 1'b0;
        repeat (10) tick();

        // ch2 blocked while pending; ch3 accepted in the same window.
        do_reset();
        t = cyc;
        drive(mk(2, 5, 1'b1));
        for (int c = 1; c <= 24; c++) push(t + c, K_BIT, 2, int'(exp_t3[c-1]), "t3_out2");
        for (int c = 6; c <= 13; c++) push(t + c, K_BIT, 3, div_wave(t + c, t + 6, 1), "t3_out3");
        push(t + 1, K_RDY, 0, 1, "t3_ready_idle");
        for (int c = 2; c <= 14; c++)
            push(t + c, K_RDY, 0, (c == 5 || c == 13) ? 1 : 0, "t3_ready");
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1)       drive(mk(2, 2, 1'b1));
            else if (k == 5)  drive(mk(3, 1, 1'b1));
            else if (k == 14) cfg_v = 1'b0;
            else              drive(mk(2, 7, 1'b0));
        end
        repeat (11) tick();

        // Write to a nonexistent channel: dropped, sticky error.
        do_reset();
        t = cyc;
        drive(mk(5, 0, 1'b1));
        push(t, K_RDY, 0, 1, "t4_ready");
        push(t, K_ERR, 0, 0, "t4_err_pre");
        for (int c = 1; c <= 5; c++) begin
            push(t + c, K_ERR, 0, 1, "t4_err");
            push(t + c, K_VEC, 0, 0, "t4_vec");
        end
        tick();
        cfg_v  = 1'b0;
        cfg_ch = '0;
        repeat (5) tick();
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_errors++;
            $display("FAIL direct_t4_err cyc=%0d actual=%0d required=1", cyc, cfg_err);
        end
        n_checks++;
        if (clk_monitor !== '0) begin
            n_errors++;
            $display("FAIL direct_t4_vec cyc=%0d actual=%0d required=0", cyc, clk_monitor);
        end

        // All channels running, global output kill for 10 cycles.
        do_reset();
        t = cyc;
        for (int k = 0; k < NUM_CH; k++) begin
            drive(mk(k, k, 1'b1));
            tick();
        end
        cfg_v = 1'b0;
        d = t + 10;
        for (int c = d - 2; c <= d + 14; c++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (k != 2)
                    push(c, K_BIT, k, (c >= d + 1 && c <= d + 10) ? 0 : div_wave(c, t + k + 1, k), "t5_out");
            end
        end
        while (cyc < d) tick();
        output_disable = 1'b1;
        repeat (10) tick();
        output_disable = 1'b0;
        repeat (5) tick();

        // Reset while ch1 has a pending update.
        do_reset();
        t = cyc;
        drive(mk(1, 3, 1'b1));
        tick();
        drive(mk(1, 9, 1'b1));
        tick();
        cfg_v = 1'b0;
        push(t + 2, K_RDY, 0, 0, "t6_ready_pend");
        tick();
        reset_n = 1'b0;
        tick();
        n_checks++;
        if (clk_monitor !== '0) begin
            n_errors++;
            $display("FAIL direct_t6_vec cyc=%0d actual=%0d required=0", cyc, clk_monitor);
        end
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL direct_t6_ready cyc=%0d actual=%0d required=1", cyc, cfg_ready);
        end
        push(t + 4, K_VEC, 0, 0, "t6_vec_reset");
        push(t + 4, K_RDY, 0, 1, "t6_ready_reset");
        push(t + 4, K_ERR, 0, 0, "t6_err_reset");
        reset_n = 1'b1;
        tick();
        drive(mk(1, INIT_DS, 1'b1));
        for (int c = 6; c <= 20; c++) push(t + c, K_BIT, 1, div_wave(t + c, t + 6, INIT_DS), "t6_out1");
        tick();
        cfg_v = 1'b0;
        repeat (16) tick();

        for (int i = 0; i < sb.size(); i++) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s cyc=%0d actual=unchecked required=checked", sb[i].name, sb[i].cyc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
